serial_receiver_32b: RTL and testbench

//  Receive side of the calculator serial link. Samples DataOut/DOutValid/clkTx
//  as driven by the serial transceiver and rebuilds the 32-bit frame
//  {A, B, ALU result, op, flags}. Presents the frame as parallel fields with a
//  one-cycle valid strobe. Used as the link-partner block and as the bench

---
 rtl/serial_receiver_32b.sv | 176 +++++++++++++++++
 tb/tb_serial_receiver_32b.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_receiver_32b.sv
// Serial link receiver: synchronises clkTx/dinValid/din and rebuilds
// the {A, B, result, op, flags} frame, presenting it with a 1-clk strobe.
//
// Ports:
//   clk, reset          system clock, async active-low reset
//   clkTx, dinValid,    bit clock, frame-active, serial data (MSB first)
//   din
//   rxFrame             last good frame
//   rxA/rxB/rxResult    WIDTH-bit fields of rxFrame, MSB side first
//   rxOp/rxFlags        rxFrame[7:4] / rxFrame[3:0]
//   rxValid             1-clk strobe on a new good frame
//   rxBusy              reception in progress
//   frameError          sticky: last frame malformed
module serial_receiver_32b #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clkTx,
    input  logic                 dinValid,
    input  logic                 din,
    output logic [3*WIDTH+7:0]   rxFrame,
    output logic [WIDTH-1:0]     rxA,
    output logic [WIDTH-1:0]     rxB,
    output logic [WIDTH-1:0]     rxResult,
    output logic [3:0]           rxOp,
    output logic [3:0]           rxFlags,
    output logic                 rxValid,
    output logic                 rxBusy,
    output logic                 frameError
);

    localparam int FRAME = 3*WIDTH + 8;
    localparam int CW    = $clog2(FRAME + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RECV = 3'd1,
        DONE = 3'd2,
        WAIT = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ck_sync_q;
    logic [SYNC_STAGES-1:0] dv_sync_q;
    logic [SYNC_STAGES-1:0] dt_sync_q;
    logic                   ck_prev_q;
    logic                   dv_prev_q;

    logic [FRAME-1:0] shift_q, shift_d;
    logic [FRAME-1:0] frame_q, frame_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic ck_s, dv_s, dt_s;
    logic strobe, dv_rise;

    assign ck_s    = ck_sync_q[SYNC_STAGES-1];
    assign dv_s    = dv_sync_q[SYNC_STAGES-1];
    assign dt_s    = dt_sync_q[SYNC_STAGES-1];
    // Falling bit clock lands mid-bit, since the sender moves din on rise.
    assign strobe  = ck_prev_q & ~ck_s;
    assign dv_rise = dv_s & ~dv_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ck_sync_q <= '0;
            dv_sync_q <= '0;
            dt_sync_q <= '0;
            ck_prev_q <= 1'b0;
            dv_prev_q <= 1'b0;
        end else begin
            ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], clkTx};
            dv_sync_q <= {dv_sync_q[SYNC_STAGES-2:0], dinValid};
            dt_sync_q <= {dt_sync_q[SYNC_STAGES-2:0], din};
            ck_prev_q <= ck_s;
            dv_prev_q <= dv_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (dv_rise) state_d = RECV;
            // Valid low wins over a coincident strobe.
            RECV: begin
                if (!dv_s) begin
                    state_d = ERR;
                end else if (strobe && cnt_q == CW'(FRAME-1)) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = WAIT;
            WAIT: if (!dv_s) state_d = IDLE;
            ERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (dv_rise) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    err_d   = 1'b0;
                end
            end
            RECV: begin
                if (dv_s && strobe) begin
                    shift_d = {shift_q[FRAME-2:0], dt_s};
                    if (cnt_q != CW'(FRAME)) cnt_d = cnt_q + CW'(1);
                end
            end
            // Frame and strobe register together so they line up.
            DONE: begin
                frame_d = shift_q;
                valid_d = 1'b1;
            end
            WAIT: if (dv_s && strobe) err_d = 1'b1;
            ERR:  err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            frame_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        rxBusy = 1'b0;
        unique case (state_q)
            RECV, DONE, WAIT: rxBusy = 1'b1;
            default:          rxBusy = 1'b0;
        endcase
    end

    assign rxValid    = valid_q;
    assign frameError = err_q;
    assign rxFrame    = frame_q;
    assign rxA        = frame_q[FRAME-1 -: WIDTH];
    assign rxB        = frame_q[FRAME-1-WIDTH -: WIDTH];
    assign rxResult   = frame_q[FRAME-1-2*WIDTH -: WIDTH];
    assign rxOp       = frame_q[7:4];
    assign rxFlags    = frame_q[3:0];

endmodule

// File: tb/tb_serial_receiver_32b.sv
// Bench for serial_receiver_32b: drives serial frames, scoreboards the
// expected frames and checks them on every rxValid strobe.
module tb_serial_receiver_32b;

    logic        clk;
    logic        reset;
    logic        clkTx;
    logic        dinValid;
    logic        din;
    logic [31:0] rxFrame;
    logic [7:0]  rxA, rxB, rxResult;
    logic [3:0]  rxOp, rxFlags;
    logic        rxValid, rxBusy, frameError;

    int n_vec = 0;
    int n_err = 0;
    int n_pulse = 0;
    int n_pushed = 0;
    logic [31:0] exp_q[$];

    serial_receiver_32b #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .clkTx(clkTx),
        .dinValid(dinValid), .din(din),
        .rxFrame(rxFrame), .rxA(rxA), .rxB(rxB),
        .rxResult(rxResult), .rxOp(rxOp), .rxFlags(rxFlags),
        .rxValid(rxValid), .rxBusy(rxBusy),
        .frameError(frameError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rxValid) begin
            logic [31:0] e;
            n_pulse++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("frame", rxFrame, e);
                chk("rxA", rxA, e[31:24]);
                chk("rxB", rxB, e[23:16]);
                chk("rxResult", rxResult, e[15:8]);
                chk("rxOp", rxOp, e[7:4]);
                chk("rxFlags", rxFlags, e[3:0]);
                chk("err_on_valid", frameError, 0);
            end
        end
    end

    task automatic send(input logic [63:0] data, input int nbits,
                        input int div, input int rst_at);
        logic [63:0] sh;
        if (nbits >= 32 && rst_at < 0) begin
            sh = data >> (nbits - 32);
            exp_q.push_back(sh[31:0]);
            n_pushed++;
        end
        dinValid = 1'b1;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (nbits - 1 - i == rst_at) begin
                reset = 1'b0;
                #1;
                chk("rst_frame", rxFrame, 0);
                chk("rst_valid", rxValid, 0);
                chk("rst_busy", rxBusy, 0);
                chk("rst_err", frameError, 0);
                dinValid = 1'b0;
                clkTx = 1'b0;
                repeat (3) tick();
                reset = 1'b1;
                repeat (div) tick();
                return;
            end
            din = data[i];
            clkTx = 1'b1;
            repeat (div / 2) tick();
            clkTx = 1'b0;
            repeat (div / 2) tick();
        end
        dinValid = 1'b0;
        din = 1'b0;
        repeat (div) tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
        repeat (4) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [31:0] r;
        int divs[3];
        reset = 1'b0;
        clkTx = 1'b0;
        dinValid = 1'b0;
        din = 1'b0;
        repeat (3) tick();
        chk("reset_frame", rxFrame, 0);
        chk("reset_valid", rxValid, 0);
        chk("reset_busy", rxBusy, 0);
        chk("reset_err", frameError, 0);
        reset = 1'b1;
        repeat (3) tick();

        send(64'h12344600, 32, 8, -1);
        drain();
        chk("t1_err", frameError, 0);
        chk("t1_pulses", n_pulse, 1);

        send(64'hFFFFFFFF, 32, 8, -1);
        send(64'h00000001, 32, 8, -1);
        drain();
        chk("t2_pulses", n_pulse, 3);
        chk("t2_frame", rxFrame, 32'h00000001);

        send(64'h000ABCDE, 20, 8, -1);
        repeat (10) tick();
        chk("t3_err", frameError, 1);
        chk("t3_keep", rxFrame, 32'h00000001);
        chk("t3_pulses", n_pulse, 3);
        send(64'hA5A5A5A5, 32, 8, -1);
        drain();
        chk("t3_err_clr", frameError, 0);

        send({30'h0, 32'hDEADBEEF, 2'b11}, 34, 8, -1);
        drain();
        chk("t4_err", frameError, 1);
        chk("t4_pulses", n_pulse, 5);

        send(64'h13572468, 32, 8, 16);
        chk("t5_busy", rxBusy, 0);
        send(64'h0F0F0F0F, 32, 8, -1);
        drain();
        chk("t5_pulses", n_pulse, 6);

        divs[0] = 4;
        divs[1] = 8;
        divs[2] = 32;
        foreach (divs[d]) begin
            for (int j = 0; j < 3; j++) begin
                r = $urandom();
                send({32'h0, r}, 32, divs[d], -1);
            end
            drain();
        end
        chk("total_pulses", n_pulse, n_pushed);
        chk("final_busy", rxBusy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
